// File: rtl/div_iter_if.sv
// Operand/result bundle between the EX stage and the iterative divider.
interface div_iter_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               div_by_zero_o;

    // EX side: issues the request, consumes the result
    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    // Divider side
    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle restoring radix-2 integer divider, {remainder, quotient} result.
module div_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_SKIP = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    div_iter_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;
    logic [WIDTH-1:0]   dvs, dvs_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               neg_q, neg_q_nxt;
    logic               neg_r, neg_r_nxt;
    logic [2*WIDTH-1:0] result_q, result_nxt;
    logic               ready_q, ready_nxt;
    logic               busy_q, busy_nxt;
    logic               dbz_q, dbz_nxt;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [CW-1:0]      lz_val;
    logic [WIDTH:0]     trial;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_step, dvd_step, quo_fix, rem_fix;

    function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + CW'(1);
            end
        end
        return n;
    endfunction

    // Operand magnitudes and one restoring step on the working registers
    always_comb begin
        op1_abs  = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? WIDTH'(-bus.opdata1_i) : bus.opdata1_i;
        op2_abs  = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? WIDTH'(-bus.opdata2_i) : bus.opdata2_i;
        lz_val   = lead_zeros(op1_abs);
        trial    = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
        q_bit    = ~trial[WIDTH];
        rem_step = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
        dvd_step = {dvd[WIDTH-2:0], q_bit};
        quo_fix  = neg_q ? WIDTH'(-dvd_step) : dvd_step;
        rem_fix  = neg_r ? WIDTH'(-rem_step) : rem_step;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; annul wins over any completion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0)                state_nxt = BYZERO;
                    else if (EARLY_SKIP && op1_abs == '0)   state_nxt = END;
                    else                                    state_nxt = ON;
                end
            end
            BYZERO:  state_nxt = bus.annul_i ? IDLE : END;
            ON: begin
                if (bus.annul_i)                 state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))  state_nxt = END;
            end
            END: begin
                if (bus.annul_i || !bus.start_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of datapath and registered outputs
    always_comb begin
        dvd_nxt    = dvd;
        dvs_nxt    = dvs;
        rem_nxt    = rem;
        cnt_nxt    = cnt;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        result_nxt = result_q;
        ready_nxt  = ready_q;
        dbz_nxt    = dbz_q;
        busy_nxt   = (state_nxt == BYZERO) || (state_nxt == ON);
        case (state)
            IDLE: begin
                if (bus.start_i && !bus.annul_i && bus.opdata2_i != '0) begin
                    dvs_nxt   = op2_abs;
                    rem_nxt   = '0;
                    neg_r_nxt = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                    neg_q_nxt = bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                    cnt_nxt   = '0;
                    dvd_nxt   = op1_abs;
                    if (EARLY_SKIP) begin
                        if (op1_abs == '0) begin
                            result_nxt = '0;
                            ready_nxt  = 1'b1;
                            dbz_nxt    = 1'b0;
                        end else begin
                            cnt_nxt = lz_val;
                            dvd_nxt = op1_abs << lz_val;
                        end
                    end
                end
            end
            BYZERO: begin
                if (!bus.annul_i) begin
                    result_nxt = '0;
                    ready_nxt  = 1'b1;
                    dbz_nxt    = 1'b1;
                end
            end
            ON: begin
                if (!bus.annul_i) begin
                    rem_nxt = rem_step;
                    dvd_nxt = dvd_step;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        result_nxt = {rem_fix, quo_fix};
                        ready_nxt  = 1'b1;
                        dbz_nxt    = 1'b0;
                    end
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    ready_nxt = 1'b0;
                    dbz_nxt   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            dvd      <= dvd_nxt;
            dvs      <= dvs_nxt;
            rem      <= rem_nxt;
            cnt      <= cnt_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            result_q <= result_nxt;
            ready_q  <= ready_nxt;
            busy_q   <= busy_nxt;
            dbz_q    <= dbz_nxt;
        end
    end

    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench: divider 0 without early skip, divider 1 with early skip.
module tb_div_iter;
    localparam int unsigned W = 32;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(W)) bus0 ();
    div_iter_if #(.WIDTH(W)) bus1 ();

    logic         start_r [2];
    logic         annul_r [2];
    logic         sgn_r   [2];
    logic [W-1:0] op1_r   [2];
    logic [W-1:0] op2_r   [2];
    logic         rdy     [2];
    logic         busy    [2];
    logic         dbz     [2];
    logic [63:0]  res     [2];

    assign bus0.start_i      = start_r[0];
    assign bus0.annul_i      = annul_r[0];
    assign bus0.signed_div_i = sgn_r[0];
    assign bus0.opdata1_i    = op1_r[0];
    assign bus0.opdata2_i    = op2_r[0];
    assign bus1.start_i      = start_r[1];
    assign bus1.annul_i      = annul_r[1];
    assign bus1.signed_div_i = sgn_r[1];
    assign bus1.opdata1_i    = op1_r[1];
    assign bus1.opdata2_i    = op2_r[1];
    assign rdy[0]  = bus0.ready_o;
    assign busy[0] = bus0.busy_o;
    assign dbz[0]  = bus0.div_by_zero_o;
    assign res[0]  = bus0.result_o;
    assign rdy[1]  = bus1.ready_o;
    assign busy[1] = bus1.busy_o;
    assign dbz[1]  = bus1.div_by_zero_o;
    assign res[1]  = bus1.result_o;

    div_iter #(.WIDTH(W), .EARLY_SKIP(1'b0)) u_div0 (.clk(clk), .rst(rst), .bus(bus0));
    div_iter #(.WIDTH(W), .EARLY_SKIP(1'b1)) u_div1 (.clk(clk), .rst(rst), .bus(bus1));

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lz32(input logic [31:0] v);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    // Reference: 64-bit signed arithmetic truncates toward zero, remainder follows dividend
    function automatic exp_t model(input int d, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      la, lb, q, r;
        logic [31:0] mag;
        e.dbz = 1'b0;
        e.lat = int'(W) + 1;
        if (b == 32'd0) begin
            e.res = '0;
            e.dbz = 1'b1;
            e.lat = 2;
            return e;
        end
        if (sgn) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        e.res = {r[31:0], q[31:0]};
        if (d == 1) begin
            mag = (sgn && a[31]) ? -a : a;
            if (mag == 32'd0) e.lat = 1;
            else              e.lat = int'(W) + 1 - lz32(mag);
        end
        return e;
    endfunction

    task automatic run_div(input int d, input string tag, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   edges;
        int   busy_n;
        bit   got;
        @(negedge clk);
        start_r[d] = 1'b1;
        sgn_r[d]   = sgn;
        op1_r[d]   = a;
        op2_r[d]   = b;
        sb.push_back(model(d, sgn, a, b));
        edges  = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy[d]) busy_n++;
            if (rdy[d]) got = 1'b1;
        end
        e = sb.pop_front();
        check({tag, ".ready_seen"}, 64'(got), 64'(1));
        check({tag, ".latency"}, 64'(edges), 64'(e.lat));
        check({tag, ".result"}, res[d], e.res);
        check({tag, ".dbz"}, 64'(dbz[d]), 64'(e.dbz));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(e.lat - 1));
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check({tag, ".hold_ready"}, 64'(rdy[d]), 64'(1));
        check({tag, ".hold_result"}, res[d], e.res);
        @(negedge clk);
        start_r[d] = 1'b0;
        op1_r[d]   = $urandom;
        op2_r[d]   = $urandom;
        @(posedge clk);
        #1;
        check({tag, ".drop_ready"}, 64'(rdy[d]), 64'(0));
        check({tag, ".drop_dbz"}, 64'(dbz[d]), 64'(0));
        check({tag, ".idle_result"}, res[d], e.res);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            annul_r[i] = 1'b0;
            sgn_r[i]   = 1'b0;
            op1_r[i]   = '0;
            op2_r[i]   = '0;
        end
        rst = 1'b0;
        #12;
        check("reset.result", res[0], 64'd0);
        check("reset.ready", 64'(rdy[0]), 64'd0);
        check("reset.busy", 64'(busy[0]), 64'd0);
        check("reset.dbz", 64'(dbz[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div(0, "u100_7", 1'b0, 32'd100, 32'd7);
        run_div(0, "s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(0, "s_mn_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(0, "div0", 1'b0, 32'h0000_1234, 32'd0);
        run_div(0, "s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_div(0, "u_big", 1'b0, 32'hFFFF_FFFF, 32'd3);

        run_div(1, "es5_2", 1'b0, 32'd5, 32'd2);
        run_div(1, "es0_5", 1'b0, 32'd0, 32'd5);
        run_div(1, "es_div0", 1'b1, 32'd0, 32'd0);
        run_div(1, "es_s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div(1, "es_full", 1'b0, 32'h8000_0001, 32'd16);

        // Annul mid-iteration, then restart immediately
        @(negedge clk);
        start_r[0] = 1'b1;
        sgn_r[0]   = 1'b0;
        op1_r[0]   = 32'd100;
        op2_r[0]   = 32'd7;
        @(posedge clk);
        #1;
        check("annul.busy_start", 64'(busy[0]), 64'd1);
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_r[0] = 1'b1;
        @(posedge clk);
        #1;
        check("annul.busy", 64'(busy[0]), 64'd0);
        check("annul.ready", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        annul_r[0] = 1'b0;
        run_div(0, "after_annul_9_3", 1'b0, 32'd9, 32'd3);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        start_r[0] = 1'b1;
        op1_r[0]   = 32'd1000;
        op2_r[0]   = 32'd7;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst.result", res[0], 64'd0);
        check("midrst.ready", 64'(rdy[0]), 64'd0);
        check("midrst.busy", 64'(busy[0]), 64'd0);
        check("midrst.result1", res[1], 64'd0);
        @(negedge clk);
        start_r[0] = 1'b0;
        rst = 1'b1;
        run_div(0, "after_rst_1000_10", 1'b0, 32'd1000, 32'd10);

        for (int i = 0; i < 8; i++) begin
            int          d;
            bit          sg;
            logic [31:0] a, b;
            d  = i % 2;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom >> $urandom_range(0, 31);
            b  = $urandom >> $urandom_range(0, 31);
            run_div(d, $sformatf("rand%0d", i), sg, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
